bpsk_frame_rx: RTL and testbench

Receive-side framer for the text link. It consumes the serial, oversampled, signed BPSK sample stream coming out of the channel model and integrates each symbol to a hard bit decision. It hunts for a sync word, then assembles the following bits into 12-bit Hamming codewords that feed the Hamming decoder. It is the far end of the transmit chain: the Hamming encoder feeding the modulator is the near end.

---
 rtl/bpsk_frame_rx_if.sv | 23 ++
 rtl/bpsk_frame_rx.sv | 156 +++++++++++++++
 tb/tb_bpsk_frame_rx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bpsk_frame_rx_if.sv
// Sample-in / codeword-out bundle of the BPSK receive framer.
// master = sample source and codeword sink; slave = the framer.
interface bpsk_frame_rx_if #(
  parameter int SAMPLE_W = 8
);
  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_valid;
  logic [11:0]                cw_out;
  logic                       cw_valid;
  logic                       cw_weak;
  logic                       sync_locked;
  logic                       frame_done;

  modport master (
    output sample_in, sample_valid,
    input  cw_out, cw_valid, cw_weak, sync_locked, frame_done
  );

  modport slave (
    input  sample_in, sample_valid,
    output cw_out, cw_valid, cw_weak, sync_locked, frame_done
  );
endinterface

// File: rtl/bpsk_frame_rx.sv
// BPSK receive framer: integrate-and-dump bit decisions, sync-word hunt, 12-bit codeword assembly.
// Optional weak-bit flagging is built only when BPSK_RX_WEAK_EN is defined.
module bpsk_frame_rx #(
  parameter int         SPS         = 4,
  parameter int         SAMPLE_W    = 8,
  parameter logic [7:0] SYNC_WORD   = 8'hA7,
  parameter int         FRAME_LEN   = 4,
  parameter int         WEAK_THRESH = 16
) (
  input  logic            clk,
  input  logic            reset,
  bpsk_frame_rx_if.slave  rx
);
  localparam int CNT_W = $clog2(SPS);
  localparam int ACC_W = SAMPLE_W + CNT_W;

  typedef enum logic {HUNT = 1'b0, PAYLOAD = 1'b1} state_t;

  if (SPS < 2 || (SPS & (SPS - 1)) != 0 || FRAME_LEN < 1 || FRAME_LEN > 255 || WEAK_THRESH < 0)
  begin : g_param_err
    $error("bpsk_frame_rx: illegal parameter combination");
  end

  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_last;
  logic                    w_bit_stb;
  logic                    w_bit;
  logic                    w_bit_weak;

  assign w_sum     = r_acc + ACC_W'(rx.sample_in);
  assign w_last    = (r_cnt == CNT_W'(SPS - 1));
  assign w_bit_stb = rx.sample_valid && w_last;
  // Tie (sum == 0) resolves to 0.
  assign w_bit     = !w_sum[ACC_W-1] && (w_sum != '0);

`ifdef BPSK_RX_WEAK_EN
  logic [ACC_W-1:0] w_mag;
  // Unsigned negation also handles the most negative sum correctly.
  assign w_mag      = w_sum[ACC_W-1] ? ACC_W'(-w_sum) : ACC_W'(w_sum);
  assign w_bit_weak = (32'(w_mag) < 32'(WEAK_THRESH));
`else
  assign w_bit_weak = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (rx.sample_valid) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  state_t      r_state, w_state;
  logic [7:0]  r_sync, w_sync;
  logic [11:0] r_shift, w_shift;
  logic [3:0]  r_bit_cnt, w_bit_cnt;
  logic [7:0]  r_cw_cnt, w_cw_cnt;
  logic        r_weak, w_weak;
  logic [11:0] r_cw_out, w_cw_out;
  logic        r_cw_valid, w_cw_valid;
  logic        r_cw_weak, w_cw_weak;
  logic        r_frame_done, w_frame_done;
  logic [7:0]  w_cw_inc;
  logic        w_weak_acc;

  assign w_cw_inc   = r_cw_cnt + 8'd1;
  assign w_weak_acc = r_weak | w_bit_weak;

  always_comb begin
    w_state      = r_state;
    w_sync       = r_sync;
    w_shift      = r_shift;
    w_bit_cnt    = r_bit_cnt;
    w_cw_cnt     = r_cw_cnt;
    w_weak       = r_weak;
    w_cw_out     = r_cw_out;
    w_cw_valid   = 1'b0;
    w_cw_weak    = 1'b0;
    w_frame_done = 1'b0;
    if (w_bit_stb) begin
      case (r_state)
        HUNT: begin
          w_sync = {r_sync[6:0], w_bit};
          if (w_sync == SYNC_WORD) begin
            w_state   = PAYLOAD;
            w_bit_cnt = '0;
            w_cw_cnt  = '0;
            w_weak    = 1'b0;
          end
        end
        PAYLOAD: begin
          w_shift = {r_shift[10:0], w_bit};
          if (r_bit_cnt == 4'd11) begin
            w_cw_out   = w_shift;
            w_cw_valid = 1'b1;
            w_cw_weak  = w_weak_acc;
            w_weak     = 1'b0;
            w_bit_cnt  = '0;
            w_cw_cnt   = w_cw_inc;
            // Last codeword of the frame: a new sync needs 8 fresh bits.
            if (w_cw_inc == 8'(FRAME_LEN)) begin
              w_frame_done = 1'b1;
              w_sync       = '0;
              w_state      = HUNT;
            end
          end else begin
            w_bit_cnt = r_bit_cnt + 4'd1;
            w_weak    = w_weak_acc;
          end
        end
        default: w_state = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= HUNT;
      r_sync       <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_cw_cnt     <= '0;
      r_weak       <= 1'b0;
      r_cw_out     <= '0;
      r_cw_valid   <= 1'b0;
      r_cw_weak    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_sync       <= w_sync;
      r_shift      <= w_shift;
      r_bit_cnt    <= w_bit_cnt;
      r_cw_cnt     <= w_cw_cnt;
      r_weak       <= w_weak;
      r_cw_out     <= w_cw_out;
      r_cw_valid   <= w_cw_valid;
      r_cw_weak    <= w_cw_weak;
      r_frame_done <= w_frame_done;
    end
  end

  assign rx.cw_out      = r_cw_out;
  assign rx.cw_valid    = r_cw_valid;
  assign rx.cw_weak     = r_cw_weak;
  assign rx.frame_done  = r_frame_done;
  assign rx.sync_locked = (r_state == PAYLOAD);
endmodule

// File: tb/tb_bpsk_frame_rx.sv
// Randomized bench for bpsk_frame_rx: two instances (FRAME_LEN 4 and 1) share one sample stream
// and are compared every cycle against a bit-level reference model; literal checks pin the model.
module tb_bpsk_frame_rx;
  localparam int SPS = 4;
`ifdef BPSK_RX_WEAK_EN
  localparam bit WEAK_EN = 1'b1;
`else
  localparam bit WEAK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              tb_reset = 1'b1;
  logic              tb_valid = 1'b0;
  logic signed [7:0] tb_sample = '0;

  bpsk_frame_rx_if #(.SAMPLE_W(8)) rx0 ();
  bpsk_frame_rx_if #(.SAMPLE_W(8)) rx1 ();
  assign rx0.sample_in = tb_sample;
  assign rx0.sample_valid = tb_valid;
  assign rx1.sample_in = tb_sample;
  assign rx1.sample_valid = tb_valid;

  bpsk_frame_rx #(.SPS(SPS), .SAMPLE_W(8), .SYNC_WORD(8'hA7), .FRAME_LEN(4), .WEAK_THRESH(16))
    u_dut0 (.clk(clk), .reset(tb_reset), .rx(rx0.slave));
  bpsk_frame_rx #(.SPS(SPS), .SAMPLE_W(8), .SYNC_WORD(8'hA7), .FRAME_LEN(1), .WEAK_THRESH(16))
    u_dut1 (.clk(clk), .reset(tb_reset), .rx(rx1.slave));

  logic [11:0] d_cw [2];
  logic        d_valid [2], d_weak [2], d_lock [2], d_fd [2];
  assign d_cw[0] = rx0.cw_out;  assign d_valid[0] = rx0.cw_valid;  assign d_weak[0] = rx0.cw_weak;
  assign d_lock[0] = rx0.sync_locked;  assign d_fd[0] = rx0.frame_done;
  assign d_cw[1] = rx1.cw_out;  assign d_valid[1] = rx1.cw_valid;  assign d_weak[1] = rx1.cw_weak;
  assign d_lock[1] = rx1.sync_locked;  assign d_fd[1] = rx1.frame_done;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: symbol sums -> bits -> sync search over the last 8 bits -> 12-bit words.
  int frame_len [2] = '{4, 1};
  int sym_sum = 0, sym_n = 0;
  int hunt_reg [2], pay_val [2], pay_n [2], ncw [2];
  bit locked [2], pay_weak [2];
  bit e_valid [2], e_weak [2], e_fd [2];
  int e_cw [2];

  task automatic model_step(input bit v, input int s, input bit r);
    bit b, wk;
    if (r) begin
      sym_sum = 0; sym_n = 0;
      for (int k = 0; k < 2; k++) begin
        hunt_reg[k] = 0; locked[k] = 0; pay_val[k] = 0; pay_n[k] = 0; pay_weak[k] = 0;
        ncw[k] = 0; e_valid[k] = 0; e_cw[k] = 0; e_weak[k] = 0; e_fd[k] = 0;
      end
      return;
    end
    for (int k = 0; k < 2; k++) begin e_valid[k] = 0; e_weak[k] = 0; e_fd[k] = 0; end
    if (!v) return;
    sym_sum += s;
    sym_n++;
    if (sym_n < SPS) return;
    b  = (sym_sum > 0);
    wk = WEAK_EN && ((sym_sum < 0 ? -sym_sum : sym_sum) < 16);
    sym_sum = 0; sym_n = 0;
    for (int k = 0; k < 2; k++) begin
      if (!locked[k]) begin
        hunt_reg[k] = (hunt_reg[k] * 2 + int'(b)) % 256;
        if (hunt_reg[k] == 'hA7) begin
          locked[k] = 1; pay_val[k] = 0; pay_n[k] = 0; pay_weak[k] = 0; ncw[k] = 0;
        end
      end else begin
        pay_val[k] = pay_val[k] * 2 + int'(b);
        pay_weak[k] |= wk;
        pay_n[k]++;
        if (pay_n[k] == 12) begin
          e_valid[k] = 1; e_cw[k] = pay_val[k]; e_weak[k] = pay_weak[k];
          pay_val[k] = 0; pay_n[k] = 0; pay_weak[k] = 0;
          ncw[k]++;
          if (ncw[k] == frame_len[k]) begin
            e_fd[k] = 1; locked[k] = 0; hunt_reg[k] = 0;
          end
        end
      end
    end
  endtask

  // Observed codewords, for the literal checks.
  logic [11:0] cap0 [$], cap1 [$];
  bit          wk0 [$];
  int          fd0 = 0, fd1 = 0;
  bit          cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cw_valid[%0d]", k), 32'(d_valid[k]), 32'(e_valid[k]));
        chk($sformatf("cw_out[%0d]", k), 32'(d_cw[k]), 32'(e_cw[k]));
        chk($sformatf("cw_weak[%0d]", k), 32'(d_weak[k]), 32'(e_weak[k]));
        chk($sformatf("frame_done[%0d]", k), 32'(d_fd[k]), 32'(e_fd[k]));
        chk($sformatf("sync_locked[%0d]", k), 32'(d_lock[k]), 32'(locked[k]));
      end
      if (d_valid[0]) begin cap0.push_back(d_cw[0]); wk0.push_back(d_weak[0]); end
      if (d_valid[1]) cap1.push_back(d_cw[1]);
      if (d_fd[0]) fd0++;
      if (d_fd[1]) fd1++;
    end
  end

  task automatic cyc(input bit v, input int s, input bit r);
    tb_valid = v; tb_sample = 8'(s); tb_reset = r;
    @(posedge clk);
    model_step(v, s, r);
    #1;
    tb_valid = 1'b0; tb_reset = 1'b0;
  endtask

  task automatic send_sample(input int s, input int gap);
    for (int g = 0; g < 4 && int'($urandom_range(0, 99)) < gap; g++)
      cyc(1'b0, int'($urandom_range(0, 255)) - 128, 1'b0);
    cyc(1'b1, s, 1'b0);
  endtask

  task automatic send_bit(input bit b, input bit noise, input int gap);
    int s;
    for (int i = 0; i < SPS; i++) begin
      s = b ? 40 : -40;
      if (noise) s += int'($urandom_range(0, 60)) - 30;
      send_sample(s, gap);
    end
  endtask

  task automatic send_sym4(input int a, input int b, input int c, input int d, input int gap);
    send_sample(a, gap); send_sample(b, gap); send_sample(c, gap); send_sample(d, gap);
  endtask

  task automatic send_word(input logic [11:0] val, input int n, input bit noise, input int gap);
    for (int i = n - 1; i >= 0; i--) send_bit(val[i], noise, gap);
  endtask

  task automatic do_reset();
    cyc(1'b0, 0, 1'b1);
    cap0.delete(); cap1.delete(); wk0.delete(); fd0 = 0; fd1 = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0);
  endtask

  task automatic chk_cap0(input string name, input logic [47:0] words);
    logic [47:0] w;
    w = words;
    chk({name, "_count"}, 32'(cap0.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < cap0.size()) chk($sformatf("%s_cw%0d", name, i), 32'(cap0[i]), 32'(w[47-12*i -: 12]));
  endtask

  initial begin
    cyc(1'b0, 0, 1'b1);
    cyc(1'b0, 0, 1'b1);
    cmp_en = 1'b1;
    chk("rst_cw_out", 32'(rx0.cw_out), 32'h0);
    chk("rst_cw_valid", 32'(rx0.cw_valid), 32'h0);
    chk("rst_sync_locked", 32'(rx0.sync_locked), 32'h0);
    chk("rst_frame_done", 32'(rx0.frame_done), 32'h0);
    chk("rst_cw_weak", 32'(rx0.cw_weak), 32'h0);
    idle(3);

    // Basic frame
    do_reset();
    send_word(12'h0A7, 8, 1'b0, 0);
    send_word(12'h5A3, 12, 1'b0, 0); send_word(12'hFFF, 12, 1'b0, 0);
    send_word(12'h000, 12, 1'b0, 0); send_word(12'h9C1, 12, 1'b0, 0);
    idle(3);
    chk_cap0("basic", 48'h5A3_FFF_000_9C1);
    chk("basic_frame_done", 32'(fd0), 32'd1);
    chk("basic_len1_cw0", 32'(cap1.size() > 0 ? cap1[0] : 12'hEEE), 32'h5A3);

    // False sync
    do_reset();
    send_word(12'h0A6, 8, 1'b0, 0);
    send_word(12'h0A7, 8, 1'b0, 0);
    for (int i = 0; i < 4; i++) send_word(12'h123, 12, 1'b0, 0);
    idle(3);
    chk_cap0("false_sync", 48'h123_123_123_123);

    // Gaps and a zero-sum tie symbol as the first bit of the first codeword
    do_reset();
    send_word(12'h0A7, 8, 1'b0, 50);
    send_sym4(10, -10, 5, -5, 50);
    send_word(12'h5A3, 11, 1'b0, 50);
    send_word(12'h3C6, 12, 1'b0, 50); send_word(12'h0F0, 12, 1'b0, 50);
    send_word(12'h777, 12, 1'b0, 50);
    idle(3);
    chk_cap0("gaps_tie", 48'h5A3_3C6_0F0_777);

    // Mid-frame reset after 6 payload bits of codeword 2
    do_reset();
    send_word(12'h0A7, 8, 1'b0, 0);
    send_word(12'hABC, 12, 1'b0, 0);
    send_word(12'hDEF >> 6, 6, 1'b0, 0);
    idle(2);
    chk("midrst_before_count", 32'(cap0.size()), 32'd1);
    do_reset();
    chk("midrst_cw_out", 32'(rx0.cw_out), 32'h0);
    chk("midrst_locked", 32'(rx0.sync_locked), 32'h0);
    send_word(12'h0A7, 8, 1'b0, 0);
    send_word(12'h111, 12, 1'b0, 0); send_word(12'h222, 12, 1'b0, 0);
    send_word(12'h333, 12, 1'b0, 0); send_word(12'h444, 12, 1'b0, 0);
    idle(3);
    chk_cap0("midrst_after", 48'h111_222_333_444);

    // Noise, with one low-magnitude '1' as the first bit of codeword 2
    do_reset();
    send_word(12'h0A7, 8, 1'b1, 25);
    send_word(12'h36C, 12, 1'b1, 25);
    send_sym4(3, 2, 1, 2, 25);
    send_word(12'h9A5, 11, 1'b1, 25);
    send_word(12'hF0F, 12, 1'b1, 25); send_word(12'h421, 12, 1'b1, 25);
    idle(3);
    chk_cap0("noise", 48'h36C_9A5_F0F_421);
    for (int i = 0; i < 4; i++)
      if (i < wk0.size()) chk($sformatf("noise_weak%0d", i), 32'(wk0[i]), 32'(WEAK_EN && i == 1));

    // Back-to-back single-codeword frames
    do_reset();
    send_word(12'h0A7, 8, 1'b0, 0); send_word(12'h5A5, 12, 1'b0, 0);
    send_word(12'h0A7, 8, 1'b0, 0); send_word(12'h1E1, 12, 1'b0, 0);
    idle(3);
    chk("b2b_count", 32'(cap1.size()), 32'd2);
    chk("b2b_cw0", 32'(cap1.size() > 0 ? cap1[0] : 12'hEEE), 32'h5A5);
    chk("b2b_cw1", 32'(cap1.size() > 1 ? cap1[1] : 12'hEEE), 32'h1E1);
    chk("b2b_frame_done", 32'(fd1), 32'd2);

    // Random bit stream with random gaps and noise
    do_reset();
    for (int i = 0; i < 120; i++) begin
      if (i % 40 == 0) send_word(12'h0A7, 8, 1'b1, 30);
      send_bit(1'($urandom_range(0, 1)), 1'b1, 30);
    end
    idle(3);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
